// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loads a program into an instruction store, then serves
// single-cycle fetches to the cpu. Define IFU_PARITY_EN to add per-word even parity.
module instr_fetch_unit #(
  parameter int          DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic [7:0]  pc,
  output logic [31:0] ins_out,
  output logic        ins_valid,
  output logic        cpu_set,
  output logic [8:0]  prog_len,
  output logic        prog_done,
  output logic        parity_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  wr_ptr;
  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] rd_data;
  logic        hit;

  logic pc_in_prog;
  logic wr_en;
  logic wr_final;
  logic load_entry;

  // 9-bit compare so a full 256-word program never wraps
  assign pc_in_prog = ({1'b0, pc} < prog_len);
  assign wr_en      = (state == LOAD) && load_valid;
  assign wr_final   = wr_en && (load_last || (wr_ptr == LAST_ADDR));
  assign load_entry = ((state == IDLE) || (state == DONE)) && load_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (load_start) state_next = LOAD;
      LOAD:       if (wr_final)   state_next = RUN;
      RUN:        if (!pc_in_prog) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    cpu_set    = 1'b0;
    case (state)
      LOAD:    load_ready = 1'b1;
      RUN:     cpu_set    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= 8'd0;
      prog_len  <= 9'd0;
      prog_done <= 1'b0;
      hit       <= 1'b0;
    end else begin
      if (load_entry) begin
        wr_ptr    <= 8'd0;
        prog_len  <= 9'd0;
        prog_done <= 1'b0;
      end else if (wr_en) begin
        wr_ptr   <= wr_ptr + 8'd1;
        prog_len <= prog_len + 9'd1;
      end else if ((state == RUN) && !pc_in_prog) begin
        prog_done <= 1'b1;
      end
      hit <= (state == RUN) && pc_in_prog;
    end
  end

  // Storage has no reset so it maps onto block RAM; hit gates the stale read data
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= load_data;
    rd_data <= mem[pc];
  end

`ifdef IFU_PARITY_EN
  logic par_mem [0:DEPTH-1];
  logic rd_par;
  logic par_bad;
  logic par_err_sticky;

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[wr_ptr] <= ^load_data;
    rd_par <= par_mem[pc];
  end

  assign par_bad = hit && (^{rd_par, rd_data});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_err_sticky <= 1'b0;
    else      par_err_sticky <= par_err_sticky | par_bad;
  end

  // Flag the error in the same cycle the bad word is presented
  assign parity_err = par_err_sticky | par_bad;
  assign ins_valid  = hit && !par_bad;
  assign ins_out    = ins_valid ? rd_data : NOP_WORD;
`else
  assign parity_err = 1'b0;
  assign ins_valid  = hit;
  assign ins_out    = hit ? rd_data : NOP_WORD;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of expected fetch results,
// one task per scenario.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = 32'h0;
  logic        load_last = 1'b0;
  logic [7:0]  pc = 8'd0;
  logic [31:0] ins_out;
  logic        ins_valid;
  logic        cpu_set;
  logic [8:0]  prog_len;
  logic        prog_done;
  logic        parity_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [0:255];
  int          model_len = 0;
  logic [32:0] exp_q [$];
  logic [32:0] exp;

  instr_fetch_unit #(.DEPTH(256), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .pc(pc), .ins_out(ins_out), .ins_valid(ins_valid), .cpu_set(cpu_set),
    .prog_len(prog_len), .prog_done(prog_done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: all called and returning at a falling edge
  task automatic start_load();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    model_len = 0;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 32'hDEADBEEF;
    model_mem[model_len] = d;
    $display("load idx=%0d data=%08h last=%0b", model_len, d, last);
    model_len++;
  endtask

  task automatic fetch(input logic [7:0] p);
    pc = p;
    if (int'(p) < model_len) exp_q.push_back({1'b1, model_mem[p]});
    else                     exp_q.push_back({1'b0, NOP});
    @(negedge clk);
    $display("fetch pc=%0d ins_out=%08h ins_valid=%0b", p, ins_out, ins_valid);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ins_out, ins_valid, load_ready, cpu_set, prog_len, prog_done, parity_err} !==
        {NOP, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got ins=%08h v=%0b rdy=%0b set=%0b len=%0d done=%0b perr=%0b want ins=%08h others 0",
               ins_out, ins_valid, load_ready, cpu_set, prog_len, prog_done, parity_err, NOP);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b0 || cpu_set !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got rdy=%0b set=%0b want 0 0", load_ready, cpu_set);
    end
  endtask

  task automatic test_load_basic();
    start_load();
    checks++;
    if (load_ready !== 1'b1 || cpu_set !== 1'b0) begin
      errors++;
      $display("FAIL load_entry got rdy=%0b set=%0b want 1 0", load_ready, cpu_set);
    end
    load_word(32'h00500093, 1'b0);
    load_word(32'h00A00113, 1'b0);
    load_word(32'h002081B3, 1'b1);
    checks++;
    if (prog_len !== 9'd3 || cpu_set !== 1'b1 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_basic got len=%0d set=%0b rdy=%0b want 3 1 0", prog_len, cpu_set, load_ready);
    end
  endtask

  task automatic test_run();
    for (int i = 0; i <= 3; i++) begin
      fetch(8'(i));
      exp = exp_q.pop_front();
      checks++;
      if ({ins_valid, ins_out} !== exp) begin
        errors++;
        $display("FAIL run_fetch pc=%0d got v=%0b ins=%08h want v=%0b ins=%08h",
                 i, ins_valid, ins_out, exp[32], exp[31:0]);
      end
    end
    checks++;
    if (prog_done !== 1'b1 || cpu_set !== 1'b0 || parity_err !== 1'b0) begin
      errors++;
      $display("FAIL run_end got done=%0b set=%0b perr=%0b want 1 0 0", prog_done, cpu_set, parity_err);
    end
  endtask

  task automatic test_stall_load();
    logic [31:0] words [4];
    words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    start_load();
    checks++;
    if (prog_done !== 1'b0 || prog_len !== 9'd0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_entry got done=%0b len=%0d rdy=%0b want 0 0 1", prog_done, prog_len, load_ready);
    end
    for (int i = 0; i < 4; i++) begin
      load_word(words[i], i == 3);
      if (i < 3) begin
        if (i == 1) load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        checks++;
        if (prog_len !== 9'(i + 1) || load_ready !== 1'b1 || cpu_set !== 1'b0) begin
          errors++;
          $display("FAIL stall_load i=%0d got len=%0d rdy=%0b set=%0b want %0d 1 0",
                   i, prog_len, load_ready, cpu_set, i + 1);
        end
      end
    end
    checks++;
    if (prog_len !== 9'd4 || cpu_set !== 1'b1) begin
      errors++;
      $display("FAIL stall_load_end got len=%0d set=%0b want 4 1", prog_len, cpu_set);
    end
    for (int i = 0; i <= 4; i++) begin
      fetch(8'(i));
      exp = exp_q.pop_front();
      checks++;
      if ({ins_valid, ins_out} !== exp) begin
        errors++;
        $display("FAIL stall_fetch pc=%0d got v=%0b ins=%08h want v=%0b ins=%08h",
                 i, ins_valid, ins_out, exp[32], exp[31:0]);
      end
    end
    checks++;
    if (prog_done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done got done=%0b want 1", prog_done);
    end
  endtask

  task automatic test_full_load();
    logic [7:0] pcs [3];
    pcs = '{8'd255, 8'd0, 8'd128};
    start_load();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        checks++;
        if (cpu_set !== 1'b0 || load_ready !== 1'b1 || prog_len !== 9'd255) begin
          errors++;
          $display("FAIL full_load_pre got set=%0b rdy=%0b len=%0d want 0 1 255", cpu_set, load_ready, prog_len);
        end
      end
      load_word($urandom, 1'b0);
    end
    checks++;
    if (prog_len !== 9'd256 || cpu_set !== 1'b1 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_load got len=%0d set=%0b rdy=%0b want 256 1 0", prog_len, cpu_set, load_ready);
    end
    for (int i = 0; i < 3; i++) begin
      fetch(pcs[i]);
      exp = exp_q.pop_front();
      checks++;
      if ({ins_valid, ins_out} !== exp) begin
        errors++;
        $display("FAIL full_fetch pc=%0d got v=%0b ins=%08h want v=%0b ins=%08h",
                 pcs[i], ins_valid, ins_out, exp[32], exp[31:0]);
      end
    end
    checks++;
    if (prog_done !== 1'b0 || cpu_set !== 1'b1) begin
      errors++;
      $display("FAIL full_no_wrap got done=%0b set=%0b want 0 1", prog_done, cpu_set);
    end
  endtask

  task automatic test_reset_mid_run();
    fetch(8'd1);
    exp = exp_q.pop_front();
    checks++;
    if ({ins_valid, ins_out} !== exp) begin
      errors++;
      $display("FAIL pre_reset_fetch got v=%0b ins=%08h want v=%0b ins=%08h",
               ins_valid, ins_out, exp[32], exp[31:0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ins_out, ins_valid, load_ready, cpu_set, prog_len, prog_done, parity_err} !==
        {NOP, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_run_reset got ins=%08h v=%0b rdy=%0b set=%0b len=%0d done=%0b perr=%0b want ins=%08h others 0",
               ins_out, ins_valid, load_ready, cpu_set, prog_len, prog_done, parity_err, NOP);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    pc = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_set !== 1'b0 || load_ready !== 1'b0 || ins_valid !== 1'b0) begin
      errors++;
      $display("FAIL stay_idle got set=%0b rdy=%0b v=%0b want 0 0 0", cpu_set, load_ready, ins_valid);
    end
    start_load();
    load_word(32'hCAFE0001, 1'b0);
    load_word(32'hCAFE0002, 1'b1);
    checks++;
    if (cpu_set !== 1'b1 || prog_len !== 9'd2) begin
      errors++;
      $display("FAIL reload_after_reset got set=%0b len=%0d want 1 2", cpu_set, prog_len);
    end
    for (int i = 0; i <= 2; i++) begin
      fetch(8'(i));
      exp = exp_q.pop_front();
      checks++;
      if ({ins_valid, ins_out} !== exp) begin
        errors++;
        $display("FAIL reload_fetch pc=%0d got v=%0b ins=%08h want v=%0b ins=%08h",
                 i, ins_valid, ins_out, exp[32], exp[31:0]);
      end
    end
  endtask

`ifdef IFU_PARITY_EN
  task automatic test_parity();
    start_load();
    load_word(32'h00500093, 1'b0);
    load_word(32'h00A00113, 1'b0);
    load_word(32'h002081B3, 1'b1);
    dut.par_mem[1] = ~dut.par_mem[1];
    for (int i = 0; i < 3; i++) begin
      fetch(8'(i));
      exp = exp_q.pop_front();
      if (i == 1) exp = {1'b0, NOP};
      checks++;
      if ({ins_valid, ins_out} !== exp || parity_err !== (i >= 1)) begin
        errors++;
        $display("FAIL parity_fetch pc=%0d got v=%0b ins=%08h perr=%0b want v=%0b ins=%08h perr=%0b",
                 i, ins_valid, ins_out, parity_err, exp[32], exp[31:0], i >= 1);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_reset got perr=%0b want 0", parity_err);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_load_basic();
    test_run();
    test_stall_load();
    test_full_load();
    test_reset_mid_run();
`ifdef IFU_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
